// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU control and its multiplier sequencer.
package alu_pkg;

    typedef enum logic [2:0] {
        AluAnd = 3'd0,
        AluOr  = 3'd1,
        AluAdd = 3'd2,
        AluSub = 3'd3,
        AluMul = 3'd4,
        AluSlt = 3'd5
    } alu_op_e;

    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;
    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctMul = 6'b011000;
    localparam logic [5:0] FunctSlt = 6'b101010;

    localparam logic [1:0] AluOpRtype = 2'b00;
    localparam logic [1:0] AluOpAdd   = 2'b01;
    localparam logic [1:0] AluOpSub   = 2'b10;
    localparam logic [1:0] AluOpOr    = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier datapath: one multiplier bit per step, product kept mod 2^DATA_W.
module mul_shift_add #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] mcand_in,
    input  logic [DATA_W-1:0] mplier_in,
    output logic [DATA_W-1:0] acc_next,
    output logic              cnt_one,
    output logic              zero
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] mplier_shift;
    logic [CntW-1:0]   cnt_q;

    always_comb begin
        acc_next     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_shift = mplier_q >> 1;
        cnt_one      = (cnt_q == CntW'(1));
        // Looks at the multiplier as it will be after this step.
        zero         = (mplier_shift == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            acc_q    <= '0;
            mcand_q  <= mcand_in;
            mplier_q <= mplier_in;
            cnt_q    <= CntW'(DATA_W);
        end else if (step) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_shift;
            cnt_q    <= cnt_q - CntW'(1);
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control decode plus the FSM that sequences multi-cycle MUL and stalls the pipe.
module alu_ctrl_seq
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    output logic [2:0]        ALUCtrl_o,
    output logic              stall_o,
    output logic              mul_done_o,
    output logic [DATA_W-1:0] mul_data_o
);

    state_e            state_q;
    alu_op_e           alu_ctrl;
    logic              start;
    logic              step;
    logic              last;
    logic              cnt_one;
    logic              zero;
    logic [DATA_W-1:0] acc_next;
    logic [DATA_W-1:0] mul_data_q;

    always_comb begin
        alu_ctrl = AluAdd;
        unique case (ALUOp_i)
            AluOpAdd: alu_ctrl = AluAdd;
            AluOpSub: alu_ctrl = AluSub;
            AluOpOr:  alu_ctrl = AluOr;
            default: begin
                case (funct_i)
                    FunctAnd: alu_ctrl = AluAnd;
                    FunctOr:  alu_ctrl = AluOr;
                    FunctAdd: alu_ctrl = AluAdd;
                    FunctSub: alu_ctrl = AluSub;
                    FunctMul: alu_ctrl = AluMul;
                    FunctSlt: alu_ctrl = AluSlt;
                    default:  alu_ctrl = AluAdd;
                endcase
            end
        endcase
    end

    assign ALUCtrl_o = alu_ctrl;

    assign start = valid_i & ~flush_i & (ALUOp_i == AluOpRtype) & (funct_i == FunctMul)
                 & (state_q == StIdle);
    assign step  = (state_q == StRun) & ~flush_i;
    assign last  = cnt_one | (EARLY_EXIT & zero);

    // Gated by reset so the stall releases asynchronously even with a MUL still presented.
    assign stall_o    = rst_i & (start | step);
    assign mul_done_o = (state_q == StDone) & ~flush_i;
    assign mul_data_o = mul_data_q;

    mul_shift_add #(
        .DATA_W(DATA_W)
    ) u_mul (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .load     (start),
        .step     (step),
        .mcand_in (data1_i),
        .mplier_in(data2_i),
        .acc_next (acc_next),
        .cnt_one  (cnt_one),
        .zero     (zero)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            mul_data_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: if (start) state_q <= StRun;
                StRun: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else if (last) begin
                        state_q    <= StDone;
                        mul_data_q <= acc_next;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench: decode sweep, full-length and early-exit MUL, flush, reset and back-to-back.
module tb_alu_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid0, valid1, flush;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] d1, d2;
    logic [2:0]  ctrl0, ctrl1;
    logic        stall0, stall1, done0, done1;
    logic [31:0] data0, data1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_ctrl_seq #(.DATA_W(32), .EARLY_EXIT(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid0), .flush_i(flush), .ALUOp_i(aluop),
        .funct_i(funct), .data1_i(d1), .data2_i(d2), .ALUCtrl_o(ctrl0), .stall_o(stall0),
        .mul_done_o(done0), .mul_data_o(data0)
    );

    alu_ctrl_seq #(.DATA_W(32), .EARLY_EXIT(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid1), .flush_i(flush), .ALUOp_i(aluop),
        .funct_i(funct), .data1_i(d1), .data2_i(d2), .ALUCtrl_o(ctrl1), .stall_o(stall1),
        .mul_done_o(done1), .mul_data_o(data1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic dec(input string tag, input logic [1:0] op, input logic [5:0] fn,
                       input logic [2:0] exp);
        aluop  = op;
        funct  = fn;
        valid0 = 1'b1;
        #1;
        chk(tag, 32'(ctrl0), 32'(exp));
        chk({tag, "_nostall"}, 32'(stall0), 32'd0);
        valid0 = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 with valids dropped.
    task automatic run_mul(input int sel, input logic [31:0] a, input logic [31:0] b,
                           input int flush_at, output int n_stall, output int n_done,
                           output logic [31:0] prod);
        logic st, dn;
        bit   fin;
        n_stall = 0;
        n_done  = 0;
        prod    = '0;
        fin     = 1'b0;
        aluop   = 2'b00;
        funct   = 6'b011000;
        d1      = a;
        d2      = b;
        if (sel == 0) valid0 = 1'b1;
        else          valid1 = 1'b1;
        for (int i = 0; i < 100 && !fin; i++) begin
            #1;
            st = (sel == 0) ? stall0 : stall1;
            dn = (sel == 0) ? done0 : done1;
            if (st) n_stall++;
            if (dn) begin
                n_done++;
                prod = (sel == 0) ? data0 : data1;
                fin  = 1'b1;
            end else if (!st && i > 0) begin
                fin = 1'b1;
            end else if (i == flush_at) begin
                flush  = 1'b1;
                valid0 = 1'b0;
                valid1 = 1'b0;
                #1;
                chk("flush_stall_drop", 32'((sel == 0) ? stall0 : stall1), 32'd0);
            end
            if (!fin) begin
                @(posedge clk);
                #1;
                flush = 1'b0;
            end
        end
        chk("mul_terminated", 32'(fin), 32'd1);
        valid0 = 1'b0;
        valid1 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          ns, nd, nns;
        logic [31:0] p;
        bit          spurious;

        rst = 1'b0; valid0 = 1'b0; valid1 = 1'b0; flush = 1'b0;
        aluop = 2'b00; funct = 6'b000000; d1 = '0; d2 = '0;
        #2;
        chk("rst_stall0", 32'(stall0), 32'd0);
        chk("rst_done0", 32'(done0), 32'd0);
        chk("rst_data0", data0, 32'd0);
        chk("rst_ctrl0", 32'(ctrl0), 32'd2);
        chk("rst_stall1", 32'(stall1), 32'd0);
        chk("rst_data1", data1, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        dec("dec_op01", 2'b01, 6'b100100, 3'd2);
        dec("dec_op10", 2'b10, 6'b100100, 3'd3);
        dec("dec_op11", 2'b11, 6'b100010, 3'd1);
        dec("dec_and", 2'b00, 6'b100100, 3'd0);
        dec("dec_or", 2'b00, 6'b100101, 3'd1);
        dec("dec_add", 2'b00, 6'b100000, 3'd2);
        dec("dec_sub", 2'b00, 6'b100010, 3'd3);
        dec("dec_slt", 2'b00, 6'b101010, 3'd5);
        dec("dec_unknown", 2'b00, 6'b111111, 3'd2);
        aluop = 2'b00; funct = 6'b011000; #1;
        chk("dec_mul", 32'(ctrl0), 32'd4);
        chk("dec_mul_invalid_nostall", 32'(stall0), 32'd0);
        @(posedge clk);
        #1;

        run_mul(0, 32'd7, 32'd6, -1, ns, nd, p);
        chk("mul7x6_stall_cycles", 32'(ns), 32'd33);
        chk("mul7x6_done_pulses", 32'(nd), 32'd1);
        chk("mul7x6_product", p, 32'd42);
        chk("mul7x6_hold", data0, 32'd42);
        chk("mul7x6_done_low_after", 32'(done0), 32'd0);

        run_mul(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, ns, nd, p);
        chk("mul_ffxff_product", p, 32'h0000_0001);

        run_mul(0, 32'hFFFF_FFFD, 32'd5, -1, ns, nd, p);
        chk("mul_neg3x5_product", p, 32'hFFFF_FFF1);

        run_mul(0, 32'd7, 32'd6, 10, ns, nd, p);
        chk("flush_no_done", 32'(nd), 32'd0);
        chk("flush_data_held", data0, 32'hFFFF_FFF1);
        chk("flush_idle_stall", 32'(stall0), 32'd0);

        run_mul(1, 32'd7, 32'd6, -1, ns, nd, p);
        chk("ee_6_stall_cycles", 32'(ns), 32'd4);
        chk("ee_6_done_pulses", 32'(nd), 32'd1);
        chk("ee_6_product", p, 32'd42);

        run_mul(1, 32'd123, 32'd0, -1, ns, nd, p);
        chk("ee_0_stall_cycles", 32'(ns), 32'd2);
        chk("ee_0_product", p, 32'd0);

        // Back-to-back with valid held high through both DONE cycles.
        aluop = 2'b00; funct = 6'b011000; d1 = 32'd3; d2 = 32'd5; valid0 = 1'b1;
        nd = 0; nns = 0;
        for (int i = 0; i < 68; i++) begin
            #1;
            if (done0) nd++;
            if (!stall0) nns++;
            @(posedge clk);
            #1;
        end
        valid0 = 1'b0;
        chk("b2b_done_pulses", 32'(nd), 32'd2);
        chk("b2b_unstalled_cycles", 32'(nns), 32'd2);
        chk("b2b_product", data0, 32'd15);
        spurious = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (done0 || stall0) spurious = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("b2b_no_restart", 32'(spurious), 32'd0);

        // Reset asserted mid-RUN.
        d1 = 32'd9; d2 = 32'd9; valid0 = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("midrun_running", 32'(stall0), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrun_rst_stall", 32'(stall0), 32'd0);
        chk("midrun_rst_done", 32'(done0), 32'd0);
        chk("midrun_rst_data", data0, 32'd0);
        valid0 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(stall0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Parametrised EX-stage ALU control with an integrated iterative multiplier sequencer. It decodes ALUOp/funct into a 3-bit ALU operation code for single-cycle ops, and runs MUL (funct 011000) as a multi-cycle shift-add operation. While MUL runs it stalls the pipeline and delivers the low DATA_W bits of the product with a done pulse. It sits between the ID/EX register and the ALU/EX-MEM result mux.

## Interface
- DATA_W, 32, operand/result width (≥4, even)
- EARLY_EXIT, 1, when 1, MUL terminates as soon as the remaining multiplier bits are all zero
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- valid_i  in  1  EX-stage instruction valid
- flush_i  in  1  abort any in-flight MUL (branch/exception flush)
- ALUOp_i  in  2  main-control ALU class
- funct_i  in  6  R-type funct field
- data1_i  in  DATA_W  multiplicand (rs)
- data2_i  in  DATA_W  multiplier (rt)
- ALUCtrl_o  out  3  ALU operation code
- stall_o  out  1  hold IF/ID/EX, insert bubble into MEM
- mul_done_o  out  1  one-cycle pulse, mul_data_o valid
- mul_data_o  out  DATA_W  product[DATA_W-1:0]

## Operation
- ALUCtrl_o is combinational and has no latches:
  - ALUOp 01 → ADD(2)
  - ALUOp 10 → SUB(3)
  - ALUOp 11 → OR(1)
  - ALUOp 00 decodes funct: 100100 → AND(0), 100101 → OR(1), 100000 → ADD(2), 100010 → SUB(3), 011000 → MUL(4), 101010 → SLT(5).
  - An unknown funct → ADD(2).
- start = valid_i & ~flush_i & (ALUOp_i==00) & (funct_i==011000) & state==IDLE.
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
  - IDLE: when start, latch acc=0, mcand=data1_i, mplier=data2_i, cnt=DATA_W → RUN.
  - RUN, each cycle:
    - If mplier[0], acc += mcand (mod 2^DATA_W).
    - Then mcand <<= 1, mplier >>= 1, cnt -= 1.
    - Go to DONE when cnt reaches 1 at this edge (i.e. the last bit is processed), or when EARLY_EXIT and the shifted mplier==0.
  - DONE: mul_done_o=1 and mul_data_o=acc → IDLE unconditionally. valid_i is ignored in DONE because the stalled MUL is still presented, so no restart.
- stall_o = start | (state==RUN). It is low in DONE.
- flush_i in RUN or DONE → IDLE next edge. No mul_done_o, acc unchanged, stall_o drops the same cycle.
- Signed and unsigned MUL yield identical low DATA_W bits, so no sign handling is needed.
- mul_data_o holds the last product until the next DONE. Reset value is 0.
- Reset values: state IDLE, acc/mcand/mplier 0, cnt 0, stall_o 0, mul_done_o 0, mul_data_o 0. ALUCtrl_o follows its inputs (ADD for all-zero inputs).
- Reset asserted mid-RUN: immediate return to IDLE, stall_o low asynchronously, no done pulse.

## Timing
- MUL accepted at edge T (start high in cycle T-1, with stall_o already high in that cycle).
- Full latency (EARLY_EXIT=0): RUN for DATA_W cycles, then DONE. stall_o is high for DATA_W+1 cycles total, and mul_done_o is high in cycle DATA_W+1 after start.
- EARLY_EXIT=1: RUN length is max(1, index of highest set multiplier bit + 1).
- Back-to-back MULs: the second start is evaluated in the IDLE cycle after DONE. There is at least one non-stalled cycle between them.
- Non-MUL instructions: zero latency, stall_o=0.

## Structure
- Shared package alu_pkg:
  - ALU op codes (AND=0, OR=1, ADD=2, SUB=3, MUL=4, SLT=5)
  - funct constants
  - ALUOp encodings
  - FSM state enum
- Sub-module mul_shift_add, the iterative datapath (acc/mcand/mplier/cnt registers and adder) with load/step/zero outputs. The top holds the decode logic and the FSM.

## Test plan
- Decode sweep: every ALUOp/funct pair listed, plus funct 111111 → codes 0,1,2,3,4,5 as specified; unknown → 2; stall_o stays 0 for all non-MUL cases.
- MUL, DATA_W=32, EARLY_EXIT=0: data1=7, data2=6 → stall_o high 33 cycles, mul_done_o one pulse, mul_data_o=42.
- MUL overflow wrap: 0xFFFFFFFF × 0xFFFFFFFF → mul_data_o=0x00000001. Also −3 × 5 (0xFFFFFFFD × 5) → 0xFFFFFFF1.
- EARLY_EXIT=1: data2=6 → RUN 3 cycles, product correct. data2=0 → RUN 1 cycle, result 0.
- flush_i asserted at RUN cycle 10 → IDLE next cycle, no mul_done_o, mul_data_o unchanged. rst_i pulsed low mid-RUN → stall_o low immediately, all outputs at reset values.
- Back-to-back MULs with valid_i held high through DONE → exactly one done pulse per MUL, an IDLE gap of 1 cycle between them, and no spurious restart in DONE.
